uart_frame_decoder: RTL and testbench

//  Sits directly downstream of the UART receiver and consumes its byte stream (valid/ready).

---
 rtl/uart_frame_pkg.sv | 24 ++
 rtl/uart_frame_if.sv | 32 +++
 rtl/uart_frame_buffer.sv | 53 +++++
 rtl/uart_frame_decoder.sv | 177 +++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART frame decoder
//
// Purpose : decoder state encoding, error code encoding, default SYNC marker.
// Ports   : none (package).
package uart_frame_pkg;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      HUNT,
      LEN,
      PAYLOAD,
      CSUM,
      EMIT
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_CSUM    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_e;

endpackage

// File: rtl/uart_frame_if.sv
// rtl/uart_frame_if.sv - byte-in / payload-out handshake bundle of the frame decoder
//
// Purpose : groups the input byte stream, output payload stream and status pulses.
// Ports   : in_valid/in_ready/in_data    byte stream from the UART receiver
//           out_valid/out_ready/out_data/out_last  payload stream to downstream
//           frame_ok, frame_error, error_code      per-frame status pulses
// Modports: master - environment side (drives input stream and out_ready)
//           slave  - decoder side
interface uart_frame_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       frame_ok;
   logic       frame_error;
   logic [1:0] error_code;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, frame_ok, frame_error, error_code
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, frame_ok, frame_error, error_code
   );

endinterface

// File: rtl/uart_frame_buffer.sv
// rtl/uart_frame_buffer.sv - payload store with write and read pointers
//
// Purpose : MAX_PAYLOAD x 8 register array filled in order during PAYLOAD and
//           replayed in order during EMIT.
// Ports   : clock, reset_n (sync, active-low)
//           clear          return both pointers to 0 (frame done or aborted)
//           wr_en/wr_data  store byte at wr_ptr, advance wr_ptr
//           rd_adv         advance rd_ptr
//           rd_data        byte at rd_ptr
//           wr_ptr, rd_ptr current pointers
module uart_frame_buffer #(
   parameter  int MAX_PAYLOAD = 16,
   localparam int PW          = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_adv,
   output logic [7:0]    rd_data,
   output logic [PW-1:0] wr_ptr,
   output logic [PW-1:0] rd_ptr
);

   // Pointers count up to MAX_PAYLOAD, the array only needs the low bits to address.
   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

   logic [7:0] mem [MAX_PAYLOAD];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_adv) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - SYNC/LEN/payload/CSUM frame decoder behind a UART receiver
//
// Purpose : hunts for SYNC_BYTE, reads LEN, buffers LEN payload bytes, checks that
//           LEN + payload + CSUM sums to 0 mod 256. Good frames are replayed on the
//           output stream with out_last on the final byte; bad frames raise a
//           one-cycle frame_error with error_code (1 bad LEN, 2 bad CSUM, 3 timeout).
// Ports   : clock, reset_n (sync, active-low)
//           bus (uart_frame_if.slave): input byte stream, output payload stream,
//           frame_ok / frame_error / error_code status pulses.
// Config  : UART_FRAME_TIMEOUT_EN enables the inter-byte idle timeout (TIMEOUT_CYCLES).
module uart_frame_decoder
   import uart_frame_pkg::*;
#(
   parameter int         MAX_PAYLOAD    = 16,
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input logic        clock,
   input logic        reset_n,
   uart_frame_if.slave bus
);

   localparam int         PW    = $clog2(MAX_PAYLOAD + 1);
   localparam logic [7:0] MAX_B = 8'(MAX_PAYLOAD);

   if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("uart_frame_decoder: MAX_PAYLOAD must be 1..255 and TIMEOUT_CYCLES >= 1");
   end

   state_e    state;
   logic [PW-1:0] len_q;
   logic [7:0]    sum_q;
   logic          frame_ok_q;
   logic          frame_error_q;
   err_code_e     error_code_q;

   logic          xfer_in;
   logic          out_xfer;
   logic          is_last;
   logic [PW-1:0] last_idx;
   logic [7:0]    csum_total;
   logic          timeout_hit;
   logic          buf_clear;
   logic          buf_wr;
   logic          buf_rd;
   logic [7:0]    buf_rd_data;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign bus.in_ready    = (state != EMIT);
   assign bus.out_valid   = (state == EMIT);
   assign bus.out_data    = buf_rd_data;
   assign bus.out_last    = (state == EMIT) && is_last;
   assign bus.frame_ok    = frame_ok_q;
   assign bus.frame_error = frame_error_q;
   assign bus.error_code  = error_code_q;

   assign xfer_in    = bus.in_valid && (state != EMIT);
   assign out_xfer   = (state == EMIT) && bus.out_ready;
   assign last_idx   = len_q - PW'(1);
   assign is_last    = (rd_ptr == last_idx);
   assign csum_total = sum_q + bus.in_data;

   assign buf_wr    = (state == PAYLOAD) && xfer_in;
   assign buf_rd    = out_xfer && !is_last;
   // Any return to HUNT after bytes may have been stored rewinds both pointers.
   assign buf_clear = (out_xfer && is_last)
                    || ((state == CSUM) && xfer_in && (csum_total != 8'd0))
                    || timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

   logic [IW-1:0] idle_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
   assign timeout_hit = ((state == LEN) || (state == PAYLOAD) || (state == CSUM))
                      && !xfer_in
                      && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if ((state == HUNT) || (state == EMIT) || xfer_in || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + IW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= HUNT;
         len_q         <= '0;
         sum_q         <= '0;
         frame_ok_q    <= 1'b0;
         frame_error_q <= 1'b0;
         error_code_q  <= ERR_NONE;
      end else begin
         frame_ok_q    <= 1'b0;
         frame_error_q <= 1'b0;
         error_code_q  <= ERR_NONE;
         case (state)
            HUNT: begin
               if (xfer_in && (bus.in_data == SYNC_BYTE)) begin
                  state <= LEN;
               end
            end
            LEN: begin
               if (xfer_in) begin
                  if ((bus.in_data == 8'd0) || (bus.in_data > MAX_B)) begin
                     frame_error_q <= 1'b1;
                     error_code_q  <= ERR_LEN;
                     state         <= HUNT;
                  end else begin
                     len_q <= bus.in_data[PW-1:0];
                     sum_q <= bus.in_data;
                     state <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (xfer_in) begin
                  sum_q <= sum_q + bus.in_data;
                  // wr_ptr still holds the index being written this cycle.
                  if (wr_ptr == last_idx) begin
                     state <= CSUM;
                  end
               end
            end
            CSUM: begin
               if (xfer_in) begin
                  if (csum_total == 8'd0) begin
                     frame_ok_q <= 1'b1;
                     state      <= EMIT;
                  end else begin
                     frame_error_q <= 1'b1;
                     error_code_q  <= ERR_CSUM;
                     state         <= HUNT;
                  end
               end
            end
            EMIT: begin
               if (out_xfer && is_last) begin
                  state <= HUNT;
               end
            end
            default: state <= HUNT;
         endcase
         // Only reachable on a cycle without an input transfer, so it never
         // collides with the per-state pulses above.
         if (timeout_hit) begin
            frame_error_q <= 1'b1;
            error_code_q  <= ERR_TIMEOUT;
            state         <= HUNT;
         end
      end
   end

   uart_frame_buffer #(
      .MAX_PAYLOAD (MAX_PAYLOAD)
   ) u_buffer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (buf_clear),
      .wr_en   (buf_wr),
      .wr_data (bus.in_data),
      .rd_adv  (buf_rd),
      .rd_data (buf_rd_data),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr)
   );

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - self-checking bench for uart_frame_decoder
module tb_uart_frame_decoder;

   localparam int         MAXP = 16;
   localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_FRAME_TIMEOUT_EN
   localparam int TO = 100;
`else
   localparam int TO = 1000;
`endif

   logic clock;
   logic reset_n;

   uart_frame_if bus ();

   uart_frame_decoder #(
      .MAX_PAYLOAD    (MAXP),
      .SYNC_BYTE      (SYNC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Observations gathered by the monitor (written only there).
   logic [7:0] got_data[$];
   logic       got_last[$];
   int         got_err[$];
   int         got_ok = 0;
   int         valid_cycles = 0;
   int         stab_bad = 0;
   int         overlap_bad = 0;
   int         both_bad = 0;
   int         code_bad = 0;
   int         ok_timing_bad = 0;
   logic       prev_stall = 1'b0;
   logic       prev_valid = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;

   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.out_valid) valid_cycles++;
         if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
         end
         if (prev_stall && !(bus.out_valid && bus.out_data === prev_data && bus.out_last === prev_last))
            stab_bad++;
         if (bus.in_ready && bus.out_valid) overlap_bad++;
         if (bus.frame_ok) begin
            got_ok++;
            if (!(bus.out_valid && !prev_valid)) ok_timing_bad++;
         end
         if (bus.frame_ok && bus.frame_error) both_bad++;
         if (bus.frame_error) got_err.push_back(int'(bus.error_code));
         else if (bus.error_code !== 2'd0) code_bad++;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_valid = bus.out_valid;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
      end else begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end
   end

   // Reference expectations and stimulus (written only by the main sequence).
   logic [7:0] stim[$];
   logic [7:0] exp_data[$];
   logic       exp_last[$];
   int         exp_err[$];
   int         exp_ok;
   int b_data, b_err, b_ok, b_valid, b_stab, b_overlap, b_both, b_code, b_okt;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Frame grammar applied to a whole byte stream; incomplete trailing frames ignored.
   function automatic void model_stream(input logic [7:0] s[$]);
      int i = 0;
      int n = s.size();
      int l, sum;
      while (i < n) begin
         if (s[i] != SYNC) begin
            i++;
            continue;
         end
         if (i + 1 >= n) break;
         l = int'(s[i+1]);
         i += 2;
         if (l == 0 || l > MAXP) begin
            exp_err.push_back(1);
            continue;
         end
         if (i + l >= n) break;
         sum = l;
         for (int k = 0; k <= l; k++) sum += int'(s[i+k]);
         if ((sum % 256) == 0) begin
            for (int k = 0; k < l; k++) begin
               exp_data.push_back(s[i+k]);
               exp_last.push_back(k == l - 1);
            end
            exp_ok++;
         end else begin
            exp_err.push_back(2);
         end
         i += l + 1;
      end
   endfunction

   function automatic void add_frame(input int l, input bit good);
      int sum = l;
      logic [7:0] b;
      stim.push_back(SYNC);
      stim.push_back(8'(l));
      if (l < 1 || l > MAXP) return;
      for (int k = 0; k < l; k++) begin
         b = 8'($urandom);
         sum += int'(b);
         stim.push_back(b);
      end
      b = 8'((256 - (sum % 256)) % 256);
      if (!good) b = b ^ 8'($urandom_range(1, 255));
      stim.push_back(b);
   endfunction

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!done && n < 300) begin
         @(negedge clock);
         done = bus.in_ready;
         @(posedge clock);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!done) chk("in_accept", 0, 1);
   endtask

   task automatic send_stim();
      foreach (stim[i]) send_byte(stim[i]);
   endtask

   task automatic begin_scn();
      stim.delete();
      exp_data.delete();
      exp_last.delete();
      exp_err.delete();
      exp_ok    = 0;
      b_data    = got_data.size();
      b_err     = got_err.size();
      b_ok      = got_ok;
      b_valid   = valid_cycles;
      b_stab    = stab_bad;
      b_overlap = overlap_bad;
      b_both    = both_bad;
      b_code    = code_bad;
      b_okt     = ok_timing_bad;
   endtask

   task automatic end_scn(input string tag, input bit ready_high);
      int nd;
      int ne;
      model_stream(stim);
      nd = got_data.size() - b_data;
      ne = got_err.size() - b_err;
      chk({tag, " out_count"}, nd, exp_data.size());
      for (int i = 0; i < nd && i < exp_data.size(); i++) begin
         chk($sformatf("%s data[%0d]", tag, i), int'(got_data[b_data+i]), int'(exp_data[i]));
         chk($sformatf("%s last[%0d]", tag, i), int'(got_last[b_data+i]), int'(exp_last[i]));
      end
      chk({tag, " ok_count"}, got_ok - b_ok, exp_ok);
      chk({tag, " err_count"}, ne, exp_err.size());
      for (int i = 0; i < ne && i < exp_err.size(); i++)
         chk($sformatf("%s err_code[%0d]", tag, i), got_err[b_err+i], exp_err[i]);
      if (ready_high) chk({tag, " valid_cycles"}, valid_cycles - b_valid, exp_data.size());
      chk({tag, " hold_stable"}, stab_bad - b_stab, 0);
      chk({tag, " ready_in_emit"}, overlap_bad - b_overlap, 0);
      chk({tag, " ok_and_err"}, both_bad - b_both, 0);
      chk({tag, " stray_code"}, code_bad - b_code, 0);
      chk({tag, " ok_timing"}, ok_timing_bad - b_okt, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      @(negedge clock);
      chk({tag, " out_valid"}, int'(bus.out_valid), 0);
      chk({tag, " out_last"}, int'(bus.out_last), 0);
      chk({tag, " frame_ok"}, int'(bus.frame_ok), 0);
      chk({tag, " frame_error"}, int'(bus.frame_error), 0);
      chk({tag, " error_code"}, int'(bus.error_code), 0);
      chk({tag, " in_ready"}, int'(bus.in_ready), 1);
   endtask

   initial begin
      int l, r, m;
      logic [7:0] b;

      // Reset state
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'd0;
      bus.out_ready = 1'b1;
      cycles(2);
      check_idle_outputs("reset");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      cycles(2);

      // 1: good 3-byte frame
      begin_scn();
      stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
      send_stim();
      cycles(10);
      end_scn("good3", 1'b1);
      chk("good3 first byte", (got_data.size() > b_data) ? int'(got_data[b_data]) : -1, 'h11);

      // 2: bad checksum
      begin_scn();
      stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
      send_stim();
      cycles(5);
      end_scn("badcsum", 1'b1);
      check_idle_outputs("badcsum hunt");

      // 3: noise then zero length and oversize length
      begin_scn();
      stim = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11};
      send_stim();
      cycles(5);
      end_scn("badlen", 1'b1);

      // 4: downstream stalls 5 cycles per byte, then a following frame
      begin_scn();
      bus.out_ready = 1'b0;
      stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
      send_stim();
      for (int k = 0; k < 3; k++) begin
         m = got_data.size();
         cycles(5);
         bus.out_ready = 1'b1;
         for (int w = 0; w < 20 && got_data.size() == m; w++) cycles(1);
         bus.out_ready = 1'b0;
      end
      bus.out_ready = 1'b1;
      add_frame(4, 1'b1);
      for (int k = 6; k < stim.size(); k++) send_byte(stim[k]);
      cycles(10);
      end_scn("stall", 1'b0);

      // 5: reset in the middle of a payload
      begin_scn();
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      reset_n = 1'b0;
      check_idle_outputs("midreset");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      begin_scn();
      add_frame(5, 1'b1);
      send_stim();
      cycles(10);
      end_scn("after_reset", 1'b1);

      // Random mix of noise, good, corrupt and illegal-length frames
      begin_scn();
      for (int f = 0; f < 25; f++) begin
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            stim.push_back(b);
         end
         r = $urandom_range(0, 9);
         if (r == 0) l = 0;
         else if (r == 1) l = $urandom_range(MAXP + 1, 255);
         else l = $urandom_range(1, MAXP);
         add_frame(l, $urandom_range(0, 3) != 0);
      end
      add_frame(MAXP, 1'b1);
      add_frame(1, 1'b1);
      send_stim();
      cycles(40);
      end_scn("random", 1'b1);

`ifdef UART_FRAME_TIMEOUT_EN
      // 6: inter-byte timeout
      begin_scn();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h11);
      cycles(TO + 5);
      chk("timeout err_count", got_err.size() - b_err, 1);
      chk("timeout err_code", (got_err.size() > b_err) ? got_err[b_err] : -1, 3);
      begin_scn();
      stim = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCB};
      send_byte(stim[0]);
      send_byte(stim[1]);
      send_byte(stim[2]);
      cycles(TO - 1);
      send_byte(stim[3]);
      send_byte(stim[4]);
      cycles(10);
      end_scn("no_timeout", 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
